nios2_oci_mem_arbiter: RTL

- Sysclk-domain controller that shares the single-port on-chip debug (OCI) RAM between two requesters.
- Requester 1 is the JTAG debug path, driven by the take_action_ocimem_a/b pulses and jdo from the debug module's sysclk half.
- Requester 2 is the CPU-side Avalon debug slave.
- Sequences each access through a one-cycle-latency RAM, grants round-robin, auto-increments the JTAG address and returns JTAG read data as MonDReg.

---
 rtl/nios2_oci_mem_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nios2_oci_mem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path and the
// CPU-side Avalon debug slave, with round-robin grants and a one-cycle-latency RAM.
module nios2_oci_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic              ram_en,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {StIdle, StJAcc, StJRd, StAAcc, StARd} state_e;
    typedef enum logic {GrantJtag, GrantAv} grant_e;

    state_e state_q, state_d;
    grant_e last_grant_q, last_grant_d;

    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [DATA_W-1:0] mon_q, mon_d;
    logic              jtag_pend_q, jtag_pend_d;
    logic              jtag_overrun_q, jtag_overrun_d;
    logic              req_wr_q, req_wr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              svc_wr_q, svc_wr_d;
    logic [DATA_W-1:0] svc_wdata_q, svc_wdata_d;

    logic av_rq;
    logic grant_j;
    logic grant_a;
    logic jaddr_inc;

    logic unused_jdo;
    assign unused_jdo = ^jdo[36:32];

    assign av_rq = av_read | av_write;

    // Arbitration: only evaluated in idle; ties go to the side not served last.
    always_comb begin
        grant_j = 1'b0;
        grant_a = 1'b0;
        if (state_q == StIdle) begin
            if (jtag_pend_q && av_rq) begin
                if (last_grant_q == GrantJtag) begin
                    grant_a = 1'b1;
                end else begin
                    grant_j = 1'b1;
                end
            end else begin
                grant_j = jtag_pend_q;
                grant_a = av_rq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_j) begin
                    state_d = StJAcc;
                end else if (grant_a) begin
                    state_d = StAAcc;
                end
            end
            StJAcc:  state_d = svc_wr_q ? StIdle : StJRd;
            StJRd:   state_d = StIdle;
            StAAcc:  state_d = av_write ? StIdle : StARd;
            StARd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_en         = 1'b0;
        ram_wren       = 1'b0;
        ram_addr       = '0;
        ram_wdata      = '0;
        av_waitrequest = 1'b1;
        av_readdata    = '0;
        unique case (state_q)
            StJAcc: begin
                ram_en    = 1'b1;
                ram_wren  = svc_wr_q;
                ram_addr  = jaddr_q;
                ram_wdata = svc_wdata_q;
            end
            StAAcc: begin
                ram_en         = 1'b1;
                ram_wren       = av_write;
                ram_addr       = av_address;
                ram_wdata      = av_writedata;
                av_waitrequest = ~av_write;
            end
            StARd: begin
                av_waitrequest = 1'b0;
                av_readdata    = ram_rdata;
            end
            default: ;
        endcase
    end

    assign jaddr_inc = ((state_q == StJAcc) && svc_wr_q) || (state_q == StJRd);

    // JTAG datapath: the pending request is copied into the service registers
    // on grant so a new request can be captured while the old one is in flight.
    always_comb begin
        jaddr_d        = jaddr_q;
        mon_d          = mon_q;
        jtag_pend_d    = jtag_pend_q;
        jtag_overrun_d = jtag_overrun_q;
        req_wr_d       = req_wr_q;
        req_wdata_d    = req_wdata_q;
        svc_wr_d       = svc_wr_q;
        svc_wdata_d    = svc_wdata_q;
        last_grant_d   = last_grant_q;

        if (jaddr_inc) begin
            jaddr_d = jaddr_q + ADDR_W'(1);
        end
        if (take_action_ocimem_a) begin
            jaddr_d        = jdo[ADDR_W-1:0];
            jtag_overrun_d = 1'b0;
        end

        if (state_q == StJRd) begin
            mon_d = ram_rdata;
        end

        if (grant_j) begin
            jtag_pend_d  = 1'b0;
            svc_wr_d     = req_wr_q;
            svc_wdata_d  = req_wdata_q;
            last_grant_d = GrantJtag;
        end else if (grant_a) begin
            last_grant_d = GrantAv;
        end

        if (take_action_ocimem_b) begin
            if (jtag_pend_q && !grant_j) begin
                jtag_overrun_d = 1'b1;
            end else begin
                jtag_pend_d = 1'b1;
                req_wr_d    = jdo[37];
                req_wdata_d = jdo[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jaddr_q        <= '0;
            mon_q          <= '0;
            jtag_pend_q    <= 1'b0;
            jtag_overrun_q <= 1'b0;
            req_wr_q       <= 1'b0;
            req_wdata_q    <= '0;
            svc_wr_q       <= 1'b0;
            svc_wdata_q    <= '0;
            last_grant_q   <= GrantJtag;
        end else begin
            jaddr_q        <= jaddr_d;
            mon_q          <= mon_d;
            jtag_pend_q    <= jtag_pend_d;
            jtag_overrun_q <= jtag_overrun_d;
            req_wr_q       <= req_wr_d;
            req_wdata_q    <= req_wdata_d;
            svc_wr_q       <= svc_wr_d;
            svc_wdata_q    <= svc_wdata_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign MonDReg      = mon_q;
    assign jtag_overrun = jtag_overrun_q;
    assign jtag_busy    = jtag_pend_q | (state_q == StJAcc) | (state_q == StJRd);

endmodule
